// File: rtl/traffic_injector.sv
`default_nettype none
// ============================================================================
// Module   : traffic_injector
// Purpose  : Per-node NoC packet injection controller. A Bernoulli request is
//            drawn each cycle from a free-running random word against a
//            programmed rate. Requests are queued as a pending count, and each
//            packet is sequenced out as a FLITS-long valid/ready flit stream.
//            Sent packets are counted, and the block stops at an optional
//            packet limit.
// Ports    : clk_i          - clock, all state updates on the rising edge
//            reset_i        - asynchronous active-high reset
//            rand_i[31:0]   - random word, fresh every cycle
//            ena_i          - injection enable (gates new requests only)
//            flit_ready_i   - router accepts the current flit
//            flit_valid_o   - flit_out_o holds a valid flit
//            flit_out_o     - {head, tail, dest[3:0], seq[9:0], idx[7:0], payload[7:0]}
//            pkt_count_o    - packets whose tail has been handshaken
//            pending_o      - packets requested but not yet started
//            busy_o         - high exactly while a packet is being sent
//            done_o         - packet limit reached (absorbing until reset)
// Revision : 1.0 - initial release
// ============================================================================
module traffic_injector #(
    parameter int RATE     = 64,   // request when rand_i[7:0] < RATE, 0..256
    parameter int FLITS    = 4,    // flits per packet, 1..255
    parameter int MAX_PKTS = 0     // packet limit, 0 = unlimited
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [31:0] rand_i,
    input  logic        ena_i,
    input  logic        flit_ready_i,
    output logic        flit_valid_o,
    output logic [31:0] flit_out_o,
    output logic [15:0] pkt_count_o,
    output logic [7:0]  pending_o,
    output logic        busy_o,
    output logic        done_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Nine bits so that RATE=256 makes every 8-bit draw request.
    localparam logic [8:0]  RATE_C   = 9'(RATE);
    localparam logic [7:0]  LAST_IDX = 8'(FLITS - 1);
    localparam logic [15:0] MAX_C    = 16'(MAX_PKTS);

    state_t      state_q;
    logic        flit_valid_q;
    logic [31:0] flit_out_q;
    logic [15:0] pkt_count_q;
    logic [7:0]  pending_q;
    logic [7:0]  pending_d;
    logic        busy_q;
    logic        done_q;

    logic        req;
    logic        start;
    logic        fire;
    logic [7:0]  idx_q;
    logic [7:0]  idx_d;
    logic [15:0] pkt_count_d;

    // Only the low twelve bits of the random word carry information here.
    logic        unused_rand_bits;
    assign unused_rand_bits = ^rand_i[31:12];

    assign req         = ena_i && !done_q && ({1'b0, rand_i[7:0]} < RATE_C);
    assign start       = (state_q == S_IDLE) && (pending_q != 8'd0);
    assign fire        = flit_valid_q && flit_ready_i;
    // The flit index lives inside the registered flit word itself.
    assign idx_q       = flit_out_q[15:8];
    assign idx_d       = idx_q + 8'd1;
    assign pkt_count_d = pkt_count_q + 16'd1;

    // Pending queue depth: a request and a start in the same cycle cancel,
    // which also covers the saturated-at-255 case.
    always_comb begin
        pending_d = pending_q;
        if (req && !start) begin
            if (pending_q != 8'hFF) begin
                pending_d = pending_q + 8'd1;
            end
        end else if (!req && start) begin
            pending_d = pending_q - 8'd1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            flit_valid_q <= 1'b0;
            flit_out_q   <= 32'd0;
            pkt_count_q  <= 16'd0;
            pending_q    <= 8'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            pending_q <= pending_d;
            case (state_q)
                S_IDLE: begin
                    if (pending_q != 8'd0) begin
                        state_q      <= S_SEND;
                        busy_q       <= 1'b1;
                        flit_valid_q <= 1'b1;
                        // Head flit: dest and payload are captured here and
                        // reused by every later flit of the packet.
                        flit_out_q   <= {1'b1, (LAST_IDX == 8'd0), rand_i[11:8],
                                         pkt_count_q[9:0], 8'd0, rand_i[7:0]};
                    end
                end
                S_SEND: begin
                    if (fire) begin
                        if (idx_q == LAST_IDX) begin
                            pkt_count_q  <= pkt_count_d;
                            flit_valid_q <= 1'b0;
                            busy_q       <= 1'b0;
                            if ((MAX_C != 16'd0) && (pkt_count_d == MAX_C)) begin
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= S_IDLE;
                            end
                        end else begin
                            flit_out_q[31]   <= 1'b0;
                            flit_out_q[30]   <= (idx_d == LAST_IDX);
                            flit_out_q[15:8] <= idx_d;
                        end
                    end
                end
                S_DONE: begin
                    flit_valid_q <= 1'b0;
                    busy_q       <= 1'b0;
                    done_q       <= 1'b1;
                end
                default: begin
                    state_q      <= S_IDLE;
                    flit_valid_q <= 1'b0;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

    assign flit_valid_o = flit_valid_q;
    assign flit_out_o   = flit_out_q;
    assign pkt_count_o  = pkt_count_q;
    assign pending_o    = pending_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_traffic_injector.sv
`default_nettype none
// ============================================================================
// Module   : tb_traffic_injector
// Purpose  : Directed self-checking bench for traffic_injector. Four
//            instances with different parameters share the stimulus; each has
//            its own reset and is exercised while the others are held in reset.
//              u_d : RATE=64,  FLITS=2               (reset, rate boundary)
//              u_a : RATE=256, FLITS=4               (streaming, backpressure,
//                                                     saturation)
//              u_b : RATE=256, FLITS=4, MAX_PKTS=3   (packet limit)
//              u_c : RATE=256, FLITS=1               (single flit, ena gating)
// Revision : 1.0 - initial release
// ============================================================================
module tb_traffic_injector;

    logic        clk = 1'b0;
    logic [31:0] r_rand;
    logic        r_ena;
    logic        r_rdy;
    logic        rst_a, rst_b, rst_c, rst_d;

    int n_cmp = 0;
    int n_bad = 0;

    logic        w_a_valid, w_b_valid, w_c_valid, w_d_valid;
    logic [31:0] w_a_out,   w_b_out,   w_c_out,   w_d_out;
    logic [15:0] w_a_cnt,   w_b_cnt,   w_c_cnt,   w_d_cnt;
    logic [7:0]  w_a_pend,  w_b_pend,  w_c_pend,  w_d_pend;
    logic        w_a_busy,  w_b_busy,  w_c_busy,  w_d_busy;
    logic        w_a_done,  w_b_done,  w_c_done,  w_d_done;

    always #5 clk = ~clk;

    traffic_injector #(.RATE(256), .FLITS(4), .MAX_PKTS(0)) u_a (
        .clk_i(clk), .reset_i(rst_a), .rand_i(r_rand), .ena_i(r_ena),
        .flit_ready_i(r_rdy), .flit_valid_o(w_a_valid), .flit_out_o(w_a_out),
        .pkt_count_o(w_a_cnt), .pending_o(w_a_pend), .busy_o(w_a_busy),
        .done_o(w_a_done));

    traffic_injector #(.RATE(256), .FLITS(4), .MAX_PKTS(3)) u_b (
        .clk_i(clk), .reset_i(rst_b), .rand_i(r_rand), .ena_i(r_ena),
        .flit_ready_i(r_rdy), .flit_valid_o(w_b_valid), .flit_out_o(w_b_out),
        .pkt_count_o(w_b_cnt), .pending_o(w_b_pend), .busy_o(w_b_busy),
        .done_o(w_b_done));

    traffic_injector #(.RATE(256), .FLITS(1), .MAX_PKTS(0)) u_c (
        .clk_i(clk), .reset_i(rst_c), .rand_i(r_rand), .ena_i(r_ena),
        .flit_ready_i(r_rdy), .flit_valid_o(w_c_valid), .flit_out_o(w_c_out),
        .pkt_count_o(w_c_cnt), .pending_o(w_c_pend), .busy_o(w_c_busy),
        .done_o(w_c_done));

    traffic_injector #(.RATE(64), .FLITS(2), .MAX_PKTS(0)) u_d (
        .clk_i(clk), .reset_i(rst_d), .rand_i(r_rand), .ena_i(r_ena),
        .flit_ready_i(r_rdy), .flit_valid_o(w_d_valid), .flit_out_o(w_d_out),
        .pkt_count_o(w_d_cnt), .pending_o(w_d_pend), .busy_o(w_d_busy),
        .done_o(w_d_done));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag, input logic v, input logic [31:0] o,
                            input logic [15:0] c, input logic [7:0] p,
                            input logic b, input logic d);
        chk({tag, "_valid"}, {31'd0, v}, 32'd0);
        chk({tag, "_out"},   o,          32'd0);
        chk({tag, "_cnt"},   {16'd0, c}, 32'd0);
        chk({tag, "_pend"},  {24'd0, p}, 32'd0);
        chk({tag, "_busy"},  {31'd0, b}, 32'd0);
        chk({tag, "_done"},  {31'd0, d}, 32'd0);
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_a  = 1'b1;
        rst_b  = 1'b1;
        rst_c  = 1'b1;
        rst_d  = 1'b1;
        r_ena  = 1'b0;
        r_rdy  = 1'b0;
        r_rand = $urandom;
        repeat (2) begin
            tick();
            r_rand = $urandom;
        end

        // ---------------- u_d: reset values and rate boundary ----------------
        rst_d  = 1'b0;
        r_rand = 32'h0000_0F80;
        r_ena  = 1'b1;
        tick();
        chk_zero("d_reset", w_d_valid, w_d_out, w_d_cnt, w_d_pend, w_d_busy, w_d_done);
        r_rand = 32'h0000_0040;              // 64 is not < 64
        tick();
        chk("d_rate64_noreq", {24'd0, w_d_pend}, 32'd0);
        chk("d_rate64_valid", {31'd0, w_d_valid}, 32'd0);
        r_rand = 32'h0000_003F;              // 63 < 64
        tick();
        chk("d_rate63_req", {24'd0, w_d_pend}, 32'd1);
        chk("d_dwell_valid", {31'd0, w_d_valid}, 32'd0);
        r_rand = 32'h0000_0A80;
        tick();
        chk("d_head_valid", {31'd0, w_d_valid}, 32'd1);
        chk("d_head_out", w_d_out, 32'hA800_0080);
        chk("d_head_pend", {24'd0, w_d_pend}, 32'd0);
        chk("d_head_busy", {31'd0, w_d_busy}, 32'd1);
        tick();
        chk("d_head_hold", w_d_out, 32'hA800_0080);
        r_rdy = 1'b1;
        tick();
        chk("d_tail_out", w_d_out, 32'h6800_0180);
        tick();
        chk("d_end_valid", {31'd0, w_d_valid}, 32'd0);
        chk("d_end_cnt", {16'd0, w_d_cnt}, 32'd1);
        chk("d_end_busy", {31'd0, w_d_busy}, 32'd0);
        rst_d = 1'b1;

        // ---------------- u_a: full rate streaming ----------------
        r_rand = 32'h0000_0755;
        r_ena  = 1'b1;
        r_rdy  = 1'b1;
        rst_a  = 1'b0;
        tick();                                                     // e1
        chk("a_e1_pend", {24'd0, w_a_pend}, 32'd1);
        chk("a_e1_valid", {31'd0, w_a_valid}, 32'd0);
        tick();                                                     // e2
        chk("a_p0_head", w_a_out, 32'h9C00_0055);
        chk("a_e2_pend", {24'd0, w_a_pend}, 32'd1);
        chk("a_e2_busy", {31'd0, w_a_busy}, 32'd1);
        tick();
        chk("a_p0_f1", w_a_out, 32'h1C00_0155);
        chk("a_e3_pend", {24'd0, w_a_pend}, 32'd2);
        tick();
        chk("a_p0_f2", w_a_out, 32'h1C00_0255);
        tick();
        chk("a_p0_tail", w_a_out, 32'h5C00_0355);
        chk("a_e5_pend", {24'd0, w_a_pend}, 32'd4);
        tick();                                                     // e6
        chk("a_e6_valid", {31'd0, w_a_valid}, 32'd0);
        chk("a_e6_cnt", {16'd0, w_a_cnt}, 32'd1);
        chk("a_e6_pend", {24'd0, w_a_pend}, 32'd5);
        r_rand = 32'h0000_0C21;
        tick();                                                     // e7
        chk("a_p1_head", w_a_out, 32'hB001_0021);
        chk("a_e7_pend", {24'd0, w_a_pend}, 32'd5);
        tick();                                                     // e8
        chk("a_p1_f1", w_a_out, 32'h3001_0121);

        // Backpressure at index 1 for 7 cycles.
        r_rdy = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("a_bp_hold", w_a_out, 32'h3001_0121);
            chk("a_bp_valid", {31'd0, w_a_valid}, 32'd1);
        end
        chk("a_bp_pend", {24'd0, w_a_pend}, 32'd13);
        r_rdy = 1'b1;
        tick();
        chk("a_p1_f2", w_a_out, 32'h3001_0221);
        tick();
        chk("a_p1_tail", w_a_out, 32'h7001_0321);
        tick();                                                     // e18
        chk("a_e18_valid", {31'd0, w_a_valid}, 32'd0);
        chk("a_e18_cnt", {16'd0, w_a_cnt}, 32'd2);
        chk("a_e18_pend", {24'd0, w_a_pend}, 32'd16);

        // Saturation: head of packet 2 stuck for 300 cycles.
        r_rdy = 1'b0;
        tick();                                                     // e19
        chk("a_p2_head", w_a_out, 32'hB002_0021);
        chk("a_e19_pend", {24'd0, w_a_pend}, 32'd16);
        repeat (100) tick();                                        // e119
        chk("a_e119_pend", {24'd0, w_a_pend}, 32'd116);
        repeat (199) tick();                                        // e318
        chk("a_sat_pend", {24'd0, w_a_pend}, 32'd255);
        chk("a_sat_head", w_a_out, 32'hB002_0021);
        chk("a_sat_valid", {31'd0, w_a_valid}, 32'd1);
        chk("a_sat_cnt", {16'd0, w_a_cnt}, 32'd2);
        r_rdy = 1'b1;
        repeat (3) tick();                                          // e321
        chk("a_p2_tail", w_a_out, 32'h7002_0321);
        tick();                                                     // e322
        chk("a_e322_cnt", {16'd0, w_a_cnt}, 32'd3);
        chk("a_e322_pend", {24'd0, w_a_pend}, 32'd255);
        tick();                                                     // e323
        chk("a_sat_start_pend", {24'd0, w_a_pend}, 32'd255);
        chk("a_p3_head", w_a_out, 32'hB003_0021);
        tick();                                                     // e324
        chk("a_p3_f1", w_a_out, 32'h3003_0121);
        rst_a = 1'b1;
        #1;
        chk_zero("a_async_reset", w_a_valid, w_a_out, w_a_cnt, w_a_pend, w_a_busy, w_a_done);
        tick();

        // ---------------- u_b: packet limit ----------------
        r_rand = 32'h0000_0000;
        r_ena  = 1'b1;
        r_rdy  = 1'b1;
        rst_b  = 1'b0;
        repeat (11) tick();                                         // e11
        chk("b_e11_cnt", {16'd0, w_b_cnt}, 32'd2);
        tick();                                                     // e12
        chk("b_p2_head", w_b_out, 32'h8002_0000);
        chk("b_e12_pend", {24'd0, w_b_pend}, 32'd9);
        repeat (3) tick();                                          // e15
        chk("b_e15_done", {31'd0, w_b_done}, 32'd0);
        chk("b_e15_cnt", {16'd0, w_b_cnt}, 32'd2);
        tick();                                                     // e16
        chk("b_e16_done", {31'd0, w_b_done}, 32'd1);
        chk("b_e16_cnt", {16'd0, w_b_cnt}, 32'd3);
        chk("b_e16_valid", {31'd0, w_b_valid}, 32'd0);
        chk("b_e16_busy", {31'd0, w_b_busy}, 32'd0);
        chk("b_e16_pend", {24'd0, w_b_pend}, 32'd13);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("b_after_valid", {31'd0, w_b_valid}, 32'd0);
            chk("b_after_pend", {24'd0, w_b_pend}, 32'd13);
            chk("b_after_done", {31'd0, w_b_done}, 32'd1);
        end
        rst_b = 1'b1;

        // ---------------- u_c: single-flit packets, ena gating ----------------
        r_rand = 32'h0000_0312;
        r_ena  = 1'b1;
        r_rdy  = 1'b1;
        rst_c  = 1'b0;
        tick();                                                     // e1
        chk("c_e1_pend", {24'd0, w_c_pend}, 32'd1);
        chk("c_e1_valid", {31'd0, w_c_valid}, 32'd0);
        tick();                                                     // e2
        chk("c_p0", w_c_out, 32'hCC00_0012);
        chk("c_e2_valid", {31'd0, w_c_valid}, 32'd1);
        tick();                                                     // e3
        chk("c_e3_valid", {31'd0, w_c_valid}, 32'd0);
        chk("c_e3_cnt", {16'd0, w_c_cnt}, 32'd1);
        chk("c_e3_pend", {24'd0, w_c_pend}, 32'd2);
        tick();                                                     // e4
        chk("c_p1", w_c_out, 32'hCC01_0012);
        chk("c_e4_pend", {24'd0, w_c_pend}, 32'd2);
        r_ena = 1'b0;
        tick();                                                     // e5
        chk("c_e5_cnt", {16'd0, w_c_cnt}, 32'd2);
        chk("c_e5_pend", {24'd0, w_c_pend}, 32'd2);
        tick();                                                     // e6
        chk("c_p2", w_c_out, 32'hCC02_0012);
        chk("c_e6_pend", {24'd0, w_c_pend}, 32'd1);
        tick();                                                     // e7
        chk("c_e7_cnt", {16'd0, w_c_cnt}, 32'd3);
        tick();                                                     // e8
        chk("c_p3", w_c_out, 32'hCC03_0012);
        chk("c_e8_pend", {24'd0, w_c_pend}, 32'd0);
        r_ena = 1'b1;
        tick();                                                     // e9
        chk("c_e9_cnt", {16'd0, w_c_cnt}, 32'd4);
        chk("c_e9_pend", {24'd0, w_c_pend}, 32'd1);
        tick();                                                     // e10
        chk("c_p4", w_c_out, 32'hCC04_0012);
        chk("c_e10_valid", {31'd0, w_c_valid}, 32'd1);
        rst_c = 1'b1;
        #1;
        chk_zero("c_async_reset", w_c_valid, w_c_out, w_c_cnt, w_c_pend, w_c_busy, w_c_done);
        repeat (2) tick();
        chk("c_held_valid", {31'd0, w_c_valid}, 32'd0);
        chk("c_held_pend", {24'd0, w_c_pend}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
